// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, constants and address decode for bus_resp
package bus_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [7:0] DI_TIMEOUT = 8'hFF;
  function automatic logic is_fast(input logic [15:0] addr, input logic [15:0] top);
    return addr <= top;
  endfunction
endpackage

// File: rtl/zp_ram.sv
// zp_ram: single-port synchronous RAM; the read register only loads on reads so writes leave it intact
module zp_ram #(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
    if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/bus_resp.sv
// bus_resp: 65C02 bus responder; zero-wait internal RAM for low addresses, req/ack handshake with timeout above
module bus_resp
  import bus_pkg::*;
#(
  parameter logic [15:0] FAST_TOP = 16'h01FF,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);
  localparam int DEPTH = int'(FAST_TOP) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d, di_q, di_d, ram_rdata;
  logic mem_we_q, mem_we_d, bus_err_q, bus_err_d, src_ram_q, src_ram_d;
  logic idle, in_req, acc_fast, acc_slow, ack_hit, timeout_hit, done_rd;
  assign idle = state_q == IDLE;
  assign in_req = state_q == REQ;
  assign acc_fast = idle && is_fast(AB, FAST_TOP);
  assign acc_slow = idle && !is_fast(AB, FAST_TOP);
  assign ack_hit = in_req && mem_ack;
  assign timeout_hit = in_req && !mem_ack && wcnt_q == WW'(TIMEOUT - 1);
  assign done_rd = (ack_hit || timeout_hit) && !mem_we_q;
  zp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .en_i    (acc_fast),
    .we_i    (WE),
    .addr_i  (AB[AW-1:0]),
    .wdata_i (DO),
    .rdata_o (ram_rdata)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = acc_slow ? REQ : (ack_hit || timeout_hit) ? IDLE : state_q;
  always_comb begin
    rdy = idle;
    mem_req = in_req;
  end
  always_comb begin
    mem_addr_d = acc_slow ? AB : mem_addr_q;
    mem_we_d = acc_slow ? WE : mem_we_q;
    mem_wdata_d = acc_slow ? DO : mem_wdata_q;
    wcnt_d = acc_slow ? '0 : (in_req && !ack_hit && !timeout_hit) ? wcnt_q + 1'b1 : wcnt_q;
    di_d = !done_rd ? di_q : ack_hit ? mem_rdata : DI_TIMEOUT;
    src_ram_d = (acc_fast && !WE) ? 1'b1 : done_rd ? 1'b0 : src_ram_q;
    bus_err_d = timeout_hit;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      mem_we_q <= 1'b0;
      mem_wdata_q <= '0;
      wcnt_q <= '0;
      di_q <= '0;
      src_ram_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_we_q <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wcnt_q <= wcnt_d;
      di_q <= di_d;
      src_ram_q <= src_ram_d;
      bus_err_q <= bus_err_d;
    end
  end
  // fast reads are served straight from the RAM's read register to avoid an extra cycle
  assign DI = src_ram_q ? ram_rdata : di_q;
  assign mem_addr = mem_addr_q;
  assign mem_we = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err = bus_err_q;
endmodule

// File: tb/tb_bus_resp.sv
// tb_bus_resp: directed self-checking bench for bus_resp
module tb_bus_resp;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] AB = 16'h01F0;
  logic [7:0] DO = 8'h00;
  logic WE = 1'b1;
  logic [7:0] DI;
  logic rdy, mem_req, mem_we, mem_ack, bus_err;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  int n = 0;
  int errs = 0;
  bus_resp dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .AB        (AB),
    .DO        (DO),
    .WE        (WE),
    .DI        (DI),
    .rdy       (rdy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic park();
    AB = 16'h01F0;
    WE = 1'b1;
    DO = 8'h00;
  endtask
  task automatic acc(input logic [15:0] a, input logic w, input logic [7:0] d);
    AB = a;
    WE = w;
    DO = d;
  endtask
  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    #12;
    chk("rst_di", 16'(DI), 16'h00);
    chk("rst_rdy", 16'(rdy), 16'h1);
    chk("rst_req", 16'(mem_req), 16'h0);
    chk("rst_we", 16'(mem_we), 16'h0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", 16'(mem_wdata), 16'h00);
    chk("rst_err", 16'(bus_err), 16'h0);
    #2 reset_n = 1'b1;
    // fast writes, including both ends of the fast region
    acc(16'h0042, 1'b1, 8'h5A); tick();
    chk("fw_rdy", 16'(rdy), 16'h1);
    chk("fw_di_hold", 16'(DI), 16'h00);
    acc(16'h0000, 1'b1, 8'hC3); tick();
    acc(16'h01FF, 1'b1, 8'hE1); tick();
    chk("fw_req", 16'(mem_req), 16'h0);
    acc(16'h0042, 1'b0, 8'h00); tick();
    chk("fr_di", 16'(DI), 16'h5A);
    chk("fr_rdy", 16'(rdy), 16'h1);
    acc(16'h01FF, 1'b0, 8'h00); tick();
    chk("fr_top_di", 16'(DI), 16'hE1);
    chk("fr_top_req", 16'(mem_req), 16'h0);
    // slow read, ack on the 3rd REQ cycle
    acc(16'hC000, 1'b0, 8'h00); tick();
    park();
    for (int i = 1; i <= 3; i++) begin
      chk("sr_rdy", 16'(rdy), 16'h0);
      chk("sr_req", 16'(mem_req), 16'h1);
      chk("sr_addr", mem_addr, 16'hC000);
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 8'h3C; end
      tick();
    end
    mem_ack = 1'b0;
    chk("sr_di", 16'(DI), 16'h3C);
    chk("sr_rdy_back", 16'(rdy), 16'h1);
    chk("sr_req_off", 16'(mem_req), 16'h0);
    chk("sr_err", 16'(bus_err), 16'h0);
    // slow write, ack on the 1st REQ cycle
    acc(16'h8000, 1'b1, 8'hA7); tick();
    park();
    chk("sw_req", 16'(mem_req), 16'h1);
    chk("sw_we", 16'(mem_we), 16'h1);
    chk("sw_wdata", 16'(mem_wdata), 16'hA7);
    chk("sw_addr", mem_addr, 16'h8000);
    chk("sw_rdy", 16'(rdy), 16'h0);
    mem_ack = 1'b1; mem_rdata = 8'h99; tick();
    mem_ack = 1'b0;
    chk("sw_rdy_back", 16'(rdy), 16'h1);
    chk("sw_req_off", 16'(mem_req), 16'h0);
    chk("sw_di_hold", 16'(DI), 16'h3C);
    // first slow address just above the fast region
    acc(16'h0200, 1'b0, 8'h00); tick();
    park();
    chk("bd_req", 16'(mem_req), 16'h1);
    chk("bd_addr", mem_addr, 16'h0200);
    mem_ack = 1'b1; mem_rdata = 8'h11; tick();
    mem_ack = 1'b0;
    chk("bd_di", 16'(DI), 16'h11);
    // timeout: 15 REQ cycles, then FF and a single bus_err pulse
    acc(16'hC100, 1'b0, 8'h00); tick();
    park();
    for (int i = 1; i <= 15; i++) begin
      chk("to_rdy", 16'(rdy), 16'h0);
      chk("to_err_low", 16'(bus_err), 16'h0);
      tick();
    end
    chk("to_rdy_back", 16'(rdy), 16'h1);
    chk("to_di", 16'(DI), 16'hFF);
    chk("to_err", 16'(bus_err), 16'h1);
    chk("to_req_off", 16'(mem_req), 16'h0);
    tick();
    chk("to_err_pulse", 16'(bus_err), 16'h0);
    chk("to_di_hold", 16'(DI), 16'hFF);
    // ack on the last allowed cycle beats the timeout
    acc(16'hC200, 1'b0, 8'h00); tick();
    park();
    for (int i = 1; i <= 15; i++) begin
      chk("la_rdy", 16'(rdy), 16'h0);
      if (i == 15) begin mem_ack = 1'b1; mem_rdata = 8'h5E; end
      tick();
    end
    mem_ack = 1'b0;
    chk("la_di", 16'(DI), 16'h5E);
    chk("la_err", 16'(bus_err), 16'h0);
    chk("la_rdy_back", 16'(rdy), 16'h1);
    tick();
    chk("la_err_after", 16'(bus_err), 16'h0);
    // reset asserted during the 2nd REQ cycle
    acc(16'hC300, 1'b0, 8'h00); tick();
    park();
    tick();
    chk("rr_req_pre", 16'(mem_req), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_req", 16'(mem_req), 16'h0);
    chk("rr_rdy", 16'(rdy), 16'h1);
    chk("rr_di", 16'(DI), 16'h00);
    acc(16'h0000, 1'b0, 8'h00);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    #1 reset_n = 1'b1;
    tick();
    chk("rr_fast_di", 16'(DI), 16'hC3);
    chk("rr_fast_rdy", 16'(rdy), 16'h1);
    chk("rr_fast_req", 16'(mem_req), 16'h0);
    park();
    tick();
    chk("rr_late_ack_req", 16'(mem_req), 16'h0);
    chk("rr_late_ack_di", 16'(DI), 16'hC3);
    chk("rr_late_ack_err", 16'(bus_err), 16'h0);
    mem_ack = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/bus_resp.md
# bus_resp

Bus responder for the 65C02 core: it sits on the core's AB/DO/WE/DI/rdy bus and returns read data or completes writes. Addresses 0..FAST_TOP (zero page and stack) are served by an internal zero-wait RAM. All other addresses go out over a req/ack handshake to an external target. `rdy` stretches core cycles during those accesses, with a timeout guard.

## Interface
- FAST_TOP, 16'h01FF: highest address of the internal fast region. Internal RAM depth is FAST_TOP+1 bytes.
- TIMEOUT, 15: maximum handshake cycles before an access is abandoned (1..255).
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- AB  in  16  core address, sampled when rdy=1.
- DO  in  8  core write data.
- WE  in  1  core write enable.
- DI  out  8  registered read data to the core.
- rdy  out  1  core ready; 0 freezes the core.
- mem_req  out  1  external request.
- mem_we  out  1  external write strobe, held with mem_req.
- mem_addr  out  16  external address.
- mem_wdata  out  8  external write data.
- mem_rdata  in  8  external read data, valid with mem_ack.
- mem_ack  in  1  external completion.
- bus_err  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE and REQ. Wait counter `wcnt`, width clog2(TIMEOUT+1).
- Access sampling: every rising edge in IDLE samples AB/WE/DO as one access. Samples in REQ are ignored; the core is frozen then.
- Fast access (AB ≤ FAST_TOP):
  - Read: DI <= ram[AB].
  - Write: ram[AB] <= DO; DI holds.
  - State stays IDLE.
- Slow access: at the sampling edge:
  - mem_addr <= AB, mem_we <= WE, mem_wdata <= DO, wcnt <= 0.
  - State -> REQ. mem_req = (state==REQ).
- REQ, at each edge:
  - mem_ack=1: DI <= mem_rdata (reads only; writes hold DI), state -> IDLE.
  - Otherwise, wcnt==TIMEOUT-1: DI <= 8'hFF (reads only), bus_err <= 1, state -> IDLE.
  - Otherwise: wcnt++.
- rdy = (state==IDLE), decoded from the state register, so it is glitch-free.
- mem_addr/mem_we/mem_wdata are stable for the whole REQ interval.
- mem_ack is ignored while mem_req=0. A stale ack after a timeout must be dropped by the target.
- Simultaneous mem_ack and timeout in the same cycle: the ack wins, with no bus_err.
- Reset values:
  - Outputs: DI=8'h00, rdy=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0.
  - Internals: state=IDLE, wcnt=0. RAM contents are not reset.
- Reset mid-REQ: mem_req drops asynchronously and the access is discarded.

## Timing
- Fast access sampled at the end of cycle N: DI is valid in cycle N+1, with no stall.
- Slow access sampled at the end of cycle N: mem_req=1 and rdy=0 from cycle N+1.
- Ack sampled at the end of cycle M: mem_req=0, rdy=1 and DI valid in cycle M+1.
- Stall cycles equal the number of REQ cycles (at least 1).
- Timeout: after exactly TIMEOUT REQ cycles, rdy=1, DI=FF and bus_err=1 in the following cycle.
- Back-to-back slow accesses have at least one IDLE cycle with mem_req=0 between requests.
- bus_err is high for exactly one cycle.

## Structure
- Package `bus_pkg`:
  - state enum (IDLE, REQ)
  - constant DI_TIMEOUT = 8'hFF
  - function `is_fast(addr, top)`
- Sub-module `zp_ram`: single-port synchronous RAM with registered read output (parameter DEPTH). Instantiated once; its output feeds the DI register mux.

## Test plan
- Fast read/write: write 8'h5A to 16'h0042, then read 16'h0042 -> DI=8'h5A the next cycle; rdy stays 1 throughout.
- Slow read: AB=16'hC000, mem_ack with mem_rdata=8'h3C on the 3rd REQ cycle -> rdy=0 for 3 cycles, then DI=8'h3C with rdy=1; mem_addr=16'hC000 stable throughout.
- Slow write: AB=16'h8000, DO=8'hA7, WE=1, ack on the 1st REQ cycle -> mem_we=1 and mem_wdata=8'hA7 for 1 cycle; DI unchanged; one stall cycle.
- Timeout: no ack, TIMEOUT=15 -> 15 REQ cycles, then DI=8'hFF, bus_err pulses once, rdy=1.
- Ack on the last allowed cycle (15th): DI=mem_rdata, bus_err stays 0.
- Reset asserted in the 2nd REQ cycle -> mem_req=0 and rdy=1 immediately. After release, a fast read of 16'h0000 proceeds normally and late acks are ignored.
